// File: rtl/multi_reg_sequencer.sv
// multi_reg_sequencer: steps through the set bits of a latched register list, one index per beat.
// Latency: first beat valid one cycle after the Start edge; one beat per cycle while Ready is high.
// Backpressure: Ready low holds the beat (Valid/Index/Last stable); Valid never depends on Ready.
//
// Ports: Clk/Reset_n (async active-low); Start/RegList/Descend sampled in IDLE;
//        Valid/Index/Last/Ready beat handshake; Busy (RUN or DONE), Done (1-cycle pulse);
//        Count/Empty describe the latched list; Offset = 4 x beats already accepted.
// Optional feature macro: MULTI_REG_SEQ_OFFSET_EN adds the Offset output and its beat counter.
module multi_reg_sequencer #(
  parameter int LIST_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [LIST_W-1:0] RegList,
  input  logic              Descend,
  input  logic              Ready,
  output logic              Valid,
  output logic [IDX_W-1:0]  Index,
  output logic              Last,
  output logic              Busy,
  output logic              Done,
  output logic [IDX_W:0]    Count,
  output logic              Empty
`ifdef MULTI_REG_SEQ_OFFSET_EN
  ,
  output logic [IDX_W+2:0]  Offset
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LIST_W-1:0] mask_q, mask_d;
  logic              desc_q, desc_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              empty_q, empty_d;
`ifdef MULTI_REG_SEQ_OFFSET_EN
  logic [IDX_W:0]    beat_q, beat_d;
`endif

  logic [IDX_W-1:0]  enc_lo, enc_hi, cur_idx;
  logic [IDX_W:0]    list_pop;
  logic              single;
  logic              run;

  // Priority encoders on the registered mask. The low encoder scans downward so the
  // lowest set bit is the last to assign; the high encoder scans upward.
  always_comb begin
    enc_lo = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (mask_q[i]) enc_lo = IDX_W'(i);
    end
    enc_hi = '0;
    for (int i = 0; i < LIST_W; i++) begin
      if (mask_q[i]) enc_hi = IDX_W'(i);
    end
  end

  always_comb begin
    list_pop = '0;
    for (int i = 0; i < LIST_W; i++) begin
      list_pop = list_pop + (IDX_W + 1)'(RegList[i]);
    end
  end

  assign cur_idx = desc_q ? enc_hi : enc_lo;
  // Exactly one bit left: nonzero and clearing the lowest set bit leaves nothing.
  assign single  = (mask_q != '0) && ((mask_q & (mask_q - LIST_W'(1))) == '0);
  assign run     = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    desc_d  = desc_q;
    count_d = count_q;
    empty_d = empty_q;
`ifdef MULTI_REG_SEQ_OFFSET_EN
    beat_d  = beat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          mask_d  = RegList;
          desc_d  = Descend;
          count_d = list_pop;
          empty_d = (RegList == '0);
`ifdef MULTI_REG_SEQ_OFFSET_EN
          beat_d  = '0;
`endif
          state_d = (RegList == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (Ready) begin
          mask_d = mask_q & ~(LIST_W'(1) << cur_idx);
`ifdef MULTI_REG_SEQ_OFFSET_EN
          beat_d = beat_q + (IDX_W + 1)'(1);
`endif
          if (single) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      desc_q  <= 1'b0;
      count_q <= '0;
      empty_q <= 1'b0;
`ifdef MULTI_REG_SEQ_OFFSET_EN
      beat_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      desc_q  <= desc_d;
      count_q <= count_d;
      empty_q <= empty_d;
`ifdef MULTI_REG_SEQ_OFFSET_EN
      beat_q  <= beat_d;
`endif
    end
  end

  assign Valid = run;
  assign Index = run ? cur_idx : '0;
  assign Last  = run & single;
  assign Busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign Done  = (state_q == ST_DONE);
  assign Count = count_q;
  assign Empty = empty_q;
`ifdef MULTI_REG_SEQ_OFFSET_EN
  assign Offset = {beat_q, 2'b00};
`endif

endmodule

// File: tb/tb_multi_reg_sequencer.sv
// Bench for multi_reg_sequencer: directed lists from the plan, then randomized lists,
// random Ready stalls and random Start noise, checked against a queue-based model.
// Expected beats are the set-bit positions of the list, in ascending or descending order.
module tb_multi_reg_sequencer;
  localparam int LW = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] reglist = '0;
  logic          desc = 1'b0;
  logic          ready = 1'b0;
  logic          valid;
  logic [IW-1:0] index;
  logic          last;
  logic          busy;
  logic          done;
  logic [IW:0]   count;
  logic          empty;
`ifdef MULTI_REG_SEQ_OFFSET_EN
  logic [IW+2:0] offset;
`endif

  int vectors = 0;
  int miscompares = 0;

  multi_reg_sequencer #(.LIST_W(LW), .IDX_W(IW)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .RegList(reglist), .Descend(desc),
    .Ready(ready), .Valid(valid), .Index(index), .Last(last), .Busy(busy),
    .Done(done), .Count(count), .Empty(empty)
`ifdef MULTI_REG_SEQ_OFFSET_EN
    , .Offset(offset)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(valid), 0);
    chk({tag, ".index"}, 32'(index), 0);
    chk({tag, ".last"},  32'(last),  0);
    chk({tag, ".busy"},  32'(busy),  0);
    chk({tag, ".done"},  32'(done),  0);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".empty"}, 32'(empty), 0);
`ifdef MULTI_REG_SEQ_OFFSET_EN
    chk({tag, ".offset"}, 32'(offset), 0);
`endif
  endtask

  // rmode: 0 = Ready always high, 1 = random Ready, 2 = Ready low for first 3 beat cycles.
  // abort_after >= 0: pull reset once that many beats have been accepted.
  task automatic run_seq(input logic [LW-1:0] list, input logic d, input int rmode,
                         input bit noise, input int abort_after);
    int q[$];
    int acc = 0;
    int cyc = 0;
    int cnt;
    for (int i = 0; i < LW; i++) begin
      if (list[i]) begin
        if (d) q.push_front(i);
        else   q.push_back(i);
      end
    end
    cnt = q.size();
    @(negedge clk);
    start = 1'b1; reglist = list; desc = d; ready = 1'b0;
    @(negedge clk);
    start = 1'b0; desc = ~d; reglist = 16'($urandom);
    #1;
    if (cnt == 0) begin
      chk("empty.valid", 32'(valid), 0);
      chk("empty.done",  32'(done),  1);
      chk("empty.busy",  32'(busy),  1);
      chk("empty.empty", 32'(empty), 1);
      chk("empty.count", 32'(count), 0);
      @(negedge clk); #1;
      chk("empty.done2",  32'(done),  0);
      chk("empty.busy2",  32'(busy),  0);
      chk("empty.valid2", 32'(valid), 0);
      chk("empty.empty2", 32'(empty), 1);
      return;
    end
    while (q.size() > 0) begin
      if (cyc > 200) begin
        vectors++; miscompares++;
        $error("FAIL timeout: %0d beats left, expected 0", q.size());
        return;
      end
      case (rmode)
        0:       ready = 1'b1;
        2:       ready = (cyc >= 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        reglist = 16'($urandom);
      end
      #1;
      chk("beat.valid", 32'(valid), 1);
      chk("beat.index", 32'(index), 32'(q[0]));
      chk("beat.last",  32'(last),  32'(q.size() == 1));
      chk("beat.busy",  32'(busy),  1);
      chk("beat.done",  32'(done),  0);
      chk("beat.count", 32'(count), 32'(cnt));
      chk("beat.empty", 32'(empty), 0);
`ifdef MULTI_REG_SEQ_OFFSET_EN
      chk("beat.offset", 32'(offset), 32'(acc * 4));
`endif
      if (abort_after >= 0 && acc == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk); #1;
        chk_all_zero("rst_hold");
        start = 1'b0; ready = 1'b0;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      if (ready) begin
        void'(q.pop_front());
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'($urandom_range(0, 1));
    #1;
    chk("fin.done",  32'(done),  1);
    chk("fin.valid", 32'(valid), 0);
    chk("fin.busy",  32'(busy),  1);
    chk("fin.last",  32'(last),  0);
    chk("fin.count", 32'(count), 32'(cnt));
    @(negedge clk); #1;
    chk("idle.done",  32'(done),  0);
    chk("idle.busy",  32'(busy),  0);
    chk("idle.valid", 32'(valid), 0);
    chk("idle.count", 32'(count), 32'(cnt));
    chk("idle.empty", 32'(empty), 0);
  endtask

  initial begin
    logic [LW-1:0] rl;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    run_seq(16'h0800, 1'b0, 0, 1'b0, -1);
    run_seq(16'h8005, 1'b0, 0, 1'b0, -1);
    run_seq(16'h8005, 1'b1, 0, 1'b0, -1);
    run_seq(16'h8005, 1'b0, 2, 1'b0, -1);
    run_seq(16'h0000, 1'b0, 0, 1'b0, -1);
    run_seq(16'hFFFF, 1'b0, 0, 1'b1, -1);
    run_seq(16'hFFFF, 1'b0, 0, 1'b1, 5);
    run_seq(16'h0003, 1'b0, 0, 1'b0, -1);
    run_seq(16'h00F0, 1'b1, 0, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       rl = '0;
        1:       rl = LW'(1) << $urandom_range(0, LW - 1);
        default: rl = 16'($urandom);
      endcase
      run_seq(rl, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multi_reg_sequencer.md
# multi_reg_sequencer

Parametrised register-list sequencer for block-transfer (LDM/STM-style) instructions. It latches an N-bit register list and emits one register index per accepted beat, in ascending or descending order, with a valid/ready handshake toward the register-file/memory datapath. It sits between the instruction decoder and the control-unit microsequencer and generalises the combinational one-hot register encoder:
- handles any number of set bits;
- sequences them over multiple cycles;
- reports count, last-beat and completion.

## Interface
Parameters:
- LIST_W, default 16: width of the register list. Must be a power of two, at least 2.
- IDX_W, default 4: index width. Must equal log2(LIST_W).

Ports:
- Clk  input  1: single clock; all state updates on the rising edge.
- Reset_n  input  1: asynchronous, active-low reset.
- Start  input  1: request to begin a sequence. Sampled only in IDLE.
- RegList  input  LIST_W: register bitmask, sampled with Start.
- Descend  input  1: 0 = lowest index first, 1 = highest index first. Sampled with Start.
- Ready  input  1: consumer accepts the current beat.
- Valid  output  1: Index holds a beat.
- Index  output  IDX_W: register number of the current beat.
- Last  output  1: the current beat is the final one.
- Busy  output  1: high in RUN and DONE.
- Done  output  1: one-cycle completion pulse.
- Count  output  IDX_W+1: number of set bits in the latched list. Range 0..LIST_W.
- Empty  output  1: the latched list was all zeros.
- Offset  output  IDX_W+3: byte offset of the current beat. Present only with MULTI_REG_SEQ_OFFSET_EN.

## Operation
State machine, 2-bit state: IDLE, RUN, DONE.
- IDLE + Start = 1:
  - Latch RegList into the working mask `mask`, latch Descend, and latch Count = popcount(RegList).
  - If RegList != 0: Empty = 0, go to RUN.
  - If RegList == 0: Empty = 1, go to DONE.
- IDLE + Start = 0: hold.
- RUN:
  - Valid = 1.
  - Index = position of the lowest set bit of `mask` (Descend = 0) or the highest set bit (Descend = 1). This is a combinational priority encode of the registered mask.
  - Last = 1 when exactly one bit of `mask` remains.
- RUN + Valid & Ready:
  - Clear bit Index in `mask`.
  - If Last = 1, go to DONE. Otherwise stay in RUN.
- RUN + Ready = 0: hold `mask`. Valid, Index and Last stay stable.
- DONE: Done = 1 for exactly one cycle, then go to IDLE.
- Start is ignored while in RUN or DONE; in-flight state is never altered.
- Count and Empty hold their latched values until the next accepted Start.
- Descend changes during RUN have no effect.
- RegList bits are used as given. Bit 0 is a legal register.
- Reset_n low, at any time including mid-sequence, immediately forces:
  - state = IDLE, mask = 0;
  - Valid = 0, Last = 0, Busy = 0, Done = 0;
  - Index = 0, Count = 0, Empty = 0, Offset = 0.
  - No partial beat is reported after reset.

## Timing
- Start-to-first-Valid latency: 1 cycle. Start is sampled at edge k; Valid is high after edge k.
- Throughput: one beat per cycle while Ready = 1.
- An N-bit list completes its last handshake at edge k+N, with Ready held at 1.
- Done is high for the cycle following the last handshake.
- Empty list: Done is high in the cycle after the Start edge; Valid never rises.
- Back-to-back sequences: a new Start is accepted in the first IDLE cycle after Done. Minimum period between Starts is N+2 cycles.
- Ready is a pure accept. Valid does not depend combinationally on Ready.

## Configuration
- MULTI_REG_SEQ_OFFSET_EN defined:
  - Adds the Offset output and a beat counter.
  - Offset = 4 × (beats already accepted in this sequence): 0 on the first beat, 4 on the second, and so on.
  - Offset clears to 0 on each accepted Start.
  - The decrement-before (DB) addressing mode uses Offset directly; the descending order reverses the register sequence, not the offset progression.
- Undefined: the Offset port and its counter are absent. All other behaviour is identical.

## Test plan
- RegList = 0x0800, Descend = 0, Ready = 1:
  - one beat with Index = 0xB, Last = 1, Count = 1;
  - Done in the next cycle;
  - Busy high for 2 cycles.
- RegList = 0x8005, Ready = 1:
  - Descend = 0 gives Index 0, 2, 15 on consecutive cycles, Last only on 15, Count = 3.
  - Descend = 1 gives 15, 2, 0.
- RegList = 0x8005, Descend = 0, Ready = 0 for 3 cycles after Valid rises:
  - Index holds 0 and Valid holds 1 through the stall;
  - then 0, 2, 15 proceed once Ready = 1.
- RegList = 0x0000:
  - Valid never asserts;
  - Empty = 1, Count = 0;
  - Done pulses 1 cycle after Start.
- Reset and Start-while-busy, with RegList = 0xFFFF:
  - Assert Start with a different list mid-sequence: it is ignored and the beats continue 0..15.
  - Drop Reset_n after beat 5: all outputs are 0 immediately.
  - A following Start with 0x0003 yields Index 0, 1.
- With MULTI_REG_SEQ_OFFSET_EN, RegList = 0x00F0, Descend = 1:
  - Index 7, 6, 5, 4;
  - Offset 0, 4, 8, 12.
